// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register field width and the pipeline controller state encoding.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } pctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_unit.sv
// Load-use comparator: a load in IDEX whose destination is read by the instruction in IFID.
import cpu_types_pkg::*;

module hazard_unit (
    input  logic     idex_memread,
    input  regbits_t idex_rt,
    input  regbits_t ifid_rs,
    input  regbits_t ifid_rt,
    output logic     lu
);

    // $zero is never a real dependency.
    assign lu = idex_memread && (idex_rt != '0) &&
                ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: latch enables, bubbles, halt and dcache watchdog.
import cpu_types_pkg::*;

module pipeline_ctrl #(
    parameter int TIMEOUT = 1023
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         ihit,
    input  logic         dhit,
    input  logic         exmem_dREN,
    input  logic         exmem_dWEN,
    input  logic         idex_memread,
    input  regbits_t     idex_rt,
    input  regbits_t     ifid_rs,
    input  regbits_t     ifid_rt,
    input  logic         exmem_branch_taken,
    input  logic         exmem_jr,
    input  logic         ifid_jump,
    input  logic         memwb_halt,
    output logic         pc_en,
    output logic         ifid_en,
    output logic         idex_en,
    output logic         exmem_en,
    output logic         memwb_en,
    output logic         ifid_flush,
    output logic         idex_flush,
    output logic         exmem_flush,
    output logic         memwb_flush,
    output logic         halt,
    output logic         mem_err,
    output logic [31:0]  stall_cnt,
    output pctrl_state_t state
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    pctrl_state_t    next_state;
    logic [WD_W-1:0] wd;
    logic            lu;
    logic            freeze;

    hazard_unit u_hazard (
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .lu           (lu)
    );

    // In RUN a freeze needs a pending access; in DWAIT only dhit releases it.
    assign freeze = (state == DWAIT) ? !dhit
                                     : ((exmem_dREN || exmem_dWEN) && !dhit);

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        next_state  = state;
        if (RST) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
            {ifid_flush, idex_flush, exmem_flush, memwb_flush} = '1;
            next_state = RUN;
        end else begin
            case (state)
                RUN, DWAIT: begin
                    if (memwb_halt) begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
                        next_state = HALTED;
                    end else if (freeze) begin
                        {pc_en, ifid_en, idex_en, exmem_en} = '0;
                        memwb_flush = 1'b1;
                        next_state  = DWAIT;
                    end else begin
                        next_state = RUN;
                        if (exmem_branch_taken || exmem_jr) begin
                            ifid_flush  = 1'b1;
                            idex_flush  = 1'b1;
                            exmem_flush = 1'b1;
                        end else if (lu) begin
                            pc_en      = 1'b0;
                            ifid_en    = 1'b0;
                            idex_flush = 1'b1;
                        end else if (ifid_jump) begin
                            ifid_flush = 1'b1;
                        end else if (!ihit) begin
                            pc_en      = 1'b0;
                            ifid_flush = 1'b1;
                        end
                    end
                end
                HALTED: begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
                end
                default: begin
                    next_state = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            halt      <= 1'b0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            wd        <= '0;
        end else begin
            state <= next_state;
            halt  <= halt || (state == HALTED);
            if ((state == RUN || state == DWAIT) && !pc_en && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
            // Watchdog only runs across consecutive DWAIT cycles and saturates at TIMEOUT.
            if (state == DWAIT && next_state == DWAIT) begin
                if (wd != WD_W'(TIMEOUT))
                    wd <= wd + 1'b1;
                if (wd == WD_W'(TIMEOUT - 1))
                    mem_err <= 1'b1;
            end else begin
                wd <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: per-scenario tasks with an expected-output queue.
import cpu_types_pkg::*;

module tb_pipeline_ctrl;

    logic         CLK = 1'b0;
    logic         RST;
    logic         ihit, dhit, exmem_dREN, exmem_dWEN, idex_memread;
    regbits_t     idex_rt, ifid_rs, ifid_rt;
    logic         exmem_branch_taken, exmem_jr, ifid_jump, memwb_halt;
    logic         pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic         ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic         halt, mem_err;
    logic [31:0]  stall_cnt;
    pctrl_state_t state;

    int checks = 0;
    int errors = 0;

    // Output vector: {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, memwb_fl}
    logic [8:0] exp_q[$];
    localparam logic [8:0] V_RUN  = 9'b11111_0000;
    localparam logic [8:0] V_RST  = 9'b00000_1111;
    localparam logic [8:0] V_LU   = 9'b00111_0100;
    localparam logic [8:0] V_FRZ  = 9'b00001_0001;
    localparam logic [8:0] V_RED  = 9'b11111_1110;
    localparam logic [8:0] V_JMP  = 9'b11111_1000;
    localparam logic [8:0] V_NOI  = 9'b01111_1000;
    localparam logic [8:0] V_HALT = 9'b00000_0000;

    typedef struct packed {
        logic     ihit, dhit, dren, dwen, memread;
        regbits_t irt, rs, rt;
        logic     br, jr, jump, mhalt;
    } stim_t;

    pipeline_ctrl #(.TIMEOUT(7)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .exmem_branch_taken(exmem_branch_taken), .exmem_jr(exmem_jr),
        .ifid_jump(ifid_jump), .memwb_halt(memwb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .halt(halt), .mem_err(mem_err), .stall_cnt(stall_cnt), .state(state)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1);
    end

    function automatic stim_t st(input logic ih, dh, drn, dwn, mr,
                                 input regbits_t irt, rs, rt,
                                 input logic br, jr, jmp, mh);
        stim_t s;
        s = '{ihit: ih, dhit: dh, dren: drn, dwen: dwn, memread: mr,
              irt: irt, rs: rs, rt: rt, br: br, jr: jr, jump: jmp, mhalt: mh};
        return s;
    endfunction

    function automatic logic [8:0] outs();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, memwb_flush};
    endfunction

    task automatic apply(input stim_t s);
        ihit = s.ihit; dhit = s.dhit; exmem_dREN = s.dren; exmem_dWEN = s.dwen;
        idex_memread = s.memread; idex_rt = s.irt; ifid_rs = s.rs; ifid_rt = s.rt;
        exmem_branch_taken = s.br; exmem_jr = s.jr; ifid_jump = s.jump; memwb_halt = s.mhalt;
    endtask

    task automatic idle();
        apply(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic do_reset();
        idle();
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] e;
        idle();
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(V_RST);
            #1;
            e = exp_q.pop_front(); checks++;
            if (outs() !== e) begin errors++; $display("FAIL reset_outs[%0d] got %b required %b", i, outs(), e); end
            @(negedge CLK);
        end
        RST = 1'b0;
        exp_q.push_back(V_RUN);
        #1;
        e = exp_q.pop_front(); checks++;
        if (outs() !== e) begin errors++; $display("FAIL release_outs got %b required %b", outs(), e); end
        @(negedge CLK);
        checks++;
        if (stall_cnt !== 32'd0 || halt !== 1'b0 || mem_err !== 1'b0 || state !== RUN) begin
            errors++;
            $display("FAIL release_regs got stall=%0d halt=%b err=%b st=%0d required 0 0 0 0",
                     stall_cnt, halt, mem_err, state);
        end
    endtask

    task automatic test_load_use();
        stim_t s[6];
        logic [8:0] v[6];
        logic [8:0] e;
        regbits_t r, o;
        r = regbits_t'($urandom_range(1, 31));
        o = (r == 5'd31) ? 5'd1 : r + 5'd1;
        do_reset();
        s[0] = st(1, 0, 0, 0, 1, 5, 5, o, 0, 0, 0, 0); v[0] = V_LU;
        s[1] = st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); v[1] = V_RUN;
        s[2] = st(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0); v[2] = V_RUN;
        s[3] = st(1, 0, 0, 0, 1, r, o, r, 0, 0, 0, 0); v[3] = V_LU;
        s[4] = st(1, 0, 0, 0, 1, r, o, o, 0, 0, 0, 0); v[4] = V_RUN;
        s[5] = st(0, 0, 0, 0, 1, r, r, o, 0, 0, 0, 0); v[5] = V_LU;
        for (int i = 0; i < 6; i++) begin
            apply(s[i]); exp_q.push_back(v[i]);
            #1;
            e = exp_q.pop_front(); checks++;
            if (outs() !== e) begin errors++; $display("FAIL load_use[%0d] got %b required %b", i, outs(), e); end
            @(negedge CLK);
        end
        checks++;
        if (stall_cnt !== 32'd3) begin errors++; $display("FAIL load_use_stall got %0d required 3", stall_cnt); end
    endtask

    task automatic test_redirect();
        stim_t s[7];
        logic [8:0] v[7];
        logic [8:0] e;
        do_reset();
        s[0] = st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); v[0] = V_JMP;
        s[1] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); v[1] = V_NOI;
        s[2] = st(0, 0, 0, 0, 1, 9, 9, 0, 1, 0, 1, 0); v[2] = V_RED;
        s[3] = st(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); v[3] = V_RED;
        s[4] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); v[4] = V_JMP;
        s[5] = st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); v[5] = V_RUN;
        s[6] = st(1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0); v[6] = V_RED;
        for (int i = 0; i < 7; i++) begin
            apply(s[i]); exp_q.push_back(v[i]);
            #1;
            e = exp_q.pop_front(); checks++;
            if (outs() !== e) begin errors++; $display("FAIL redirect[%0d] got %b required %b", i, outs(), e); end
            @(negedge CLK);
        end
        checks++;
        if (stall_cnt !== 32'd1) begin errors++; $display("FAIL redirect_stall got %0d required 1", stall_cnt); end
    endtask

    task automatic test_dcache_miss();
        stim_t s[7];
        logic [8:0] v[7];
        logic [8:0] e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s[i] = st(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); v[i] = V_FRZ;
        end
        s[4] = st(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); v[4] = V_RUN;
        s[5] = st(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); v[5] = V_RUN;
        s[6] = st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); v[6] = V_RUN;
        for (int i = 0; i < 7; i++) begin
            apply(s[i]); exp_q.push_back(v[i]);
            #1;
            e = exp_q.pop_front(); checks++;
            if (outs() !== e) begin errors++; $display("FAIL dmiss[%0d] got %b required %b", i, outs(), e); end
            if (i == 2) begin
                checks++;
                if (state !== DWAIT) begin errors++; $display("FAIL dmiss_state got %0d required %0d", state, DWAIT); end
            end
            @(negedge CLK);
        end
        checks++;
        if (stall_cnt !== 32'd4 || state !== RUN) begin
            errors++;
            $display("FAIL dmiss_stall got stall=%0d st=%0d required 4 %0d", stall_cnt, state, RUN);
        end
    endtask

    task automatic test_branch_under_miss();
        stim_t s[5];
        logic [8:0] v[5];
        logic [8:0] e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            s[i] = st(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0); v[i] = V_FRZ;
        end
        s[3] = st(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0); v[3] = V_RED;
        s[4] = st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); v[4] = V_RUN;
        for (int i = 0; i < 5; i++) begin
            apply(s[i]); exp_q.push_back(v[i]);
            #1;
            e = exp_q.pop_front(); checks++;
            if (outs() !== e) begin errors++; $display("FAIL br_miss[%0d] got %b required %b", i, outs(), e); end
            @(negedge CLK);
        end
        checks++;
        if (stall_cnt !== 32'd3) begin errors++; $display("FAIL br_miss_stall got %0d required 3", stall_cnt); end
    endtask

    task automatic test_watchdog();
        logic [8:0] e;
        logic exp_err;
        do_reset();
        apply(st(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back(V_FRZ);
            exp_err = (k >= 8);
            #1;
            e = exp_q.pop_front(); checks++;
            if (outs() !== e) begin errors++; $display("FAIL wd_outs[%0d] got %b required %b", k, outs(), e); end
            checks++;
            if (mem_err !== exp_err) begin errors++; $display("FAIL wd_err[%0d] got %b required %b", k, mem_err, exp_err); end
            @(negedge CLK);
        end
        apply(st(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(V_RUN);
        #1;
        e = exp_q.pop_front(); checks++;
        if (outs() !== e) begin errors++; $display("FAIL wd_release got %b required %b", outs(), e); end
        @(negedge CLK);
        idle();
        @(negedge CLK);
        checks++;
        if (mem_err !== 1'b1 || state !== RUN) begin
            errors++; $display("FAIL wd_sticky got err=%b st=%0d required 1 %0d", mem_err, state, RUN);
        end
        // Reset arriving in the middle of a DWAIT.
        apply(st(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge CLK);
        RST = 1'b1;
        exp_q.push_back(V_RST);
        #1;
        e = exp_q.pop_front(); checks++;
        if (outs() !== e) begin errors++; $display("FAIL dwait_rst got %b required %b", outs(), e); end
        @(negedge CLK);
        RST = 1'b0;
        idle();
        checks++;
        if (mem_err !== 1'b0 || state !== RUN || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL dwait_rst_regs got err=%b st=%0d stall=%0d required 0 %0d 0", mem_err, state, stall_cnt, RUN);
        end
    endtask

    task automatic test_halt();
        stim_t s[4];
        logic [8:0] e;
        logic exp_h;
        do_reset();
        s[0] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        s[1] = st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s[2] = st(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        s[3] = st(0, 0, 0, 0, 1, 3, 3, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            apply(s[i]); exp_q.push_back(V_HALT);
            exp_h = (i >= 2);
            #1;
            e = exp_q.pop_front(); checks++;
            if (outs() !== e) begin errors++; $display("FAIL halt_outs[%0d] got %b required %b", i, outs(), e); end
            checks++;
            if (halt !== exp_h) begin errors++; $display("FAIL halt_flag[%0d] got %b required %b", i, halt, exp_h); end
            @(negedge CLK);
        end
        checks++;
        if (state !== HALTED || stall_cnt !== 32'd1) begin
            errors++; $display("FAIL halt_regs got st=%0d stall=%0d required %0d 1", state, stall_cnt, HALTED);
        end
        idle();
        RST = 1'b1;
        exp_q.push_back(V_RST);
        #1;
        e = exp_q.pop_front(); checks++;
        if (outs() !== e) begin errors++; $display("FAIL halt_rst got %b required %b", outs(), e); end
        @(negedge CLK);
        RST = 1'b0;
        exp_q.push_back(V_RUN);
        #1;
        e = exp_q.pop_front(); checks++;
        if (outs() !== e || halt !== 1'b0 || state !== RUN) begin
            errors++; $display("FAIL halt_clear got outs=%b halt=%b st=%0d required %b 0 %0d", outs(), halt, state, e, RUN);
        end
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1;
        idle();
        @(negedge CLK);
        test_reset();
        test_load_use();
        test_redirect();
        test_dcache_miss();
        test_branch_under_miss();
        test_watchdog();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
